// File: rtl/signed_balance_drain_if.sv
// signed_balance_drain_if
//   Groups the delta-input and chunk-output handshakes of signed_balance_drain.
//   Signals:
//     in_valid   : master -> slave, in_delta is valid
//     in_ready   : slave -> master, block accepts a delta this cycle
//     in_delta   : master -> slave, signed 5-bit delta
//     settle_req : master -> slave, single-cycle request to start draining
//     out_valid  : slave -> master, out_value holds a chunk
//     out_ready  : master -> slave, downstream accepts the chunk
//     out_value  : slave -> master, signed 5-bit chunk
//   Modports: master (feeder / downstream side), slave (signed_balance_drain).
interface signed_balance_drain_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_delta;
  logic       settle_req;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_value;

  modport master (
    output in_valid, in_delta, settle_req, out_ready,
    input  in_ready, out_valid, out_value
  );

  modport slave (
    input  in_valid, in_delta, settle_req, out_ready,
    output in_ready, out_valid, out_value
  );
endinterface

// File: rtl/signed_balance_drain.sv
// signed_balance_drain
//   Accumulates signed 5-bit deltas into a saturating signed balance and, on a
//   settle request, drains that balance as signed chunks bounded to
//   +/-DRAIN_MAX over a valid/ready handshake. Chunks never reach -16.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     clear       : synchronous clear of balance, sticky flag and FSM
//     bus         : signed_balance_drain_if.slave (delta in, chunk out)
//     balance     : current signed balance (ACC_W bits)
//     is_negative : sign bit of balance
//     sat_flag    : sticky, set when an accumulation clamped
//     settle_done : one-cycle pulse when a settlement completes
//     chunk_count : (CHUNK_COUNT_EN only) saturating count of chunks drained
//   Parameters: ACC_W (6..16), DRAIN_MAX (1..15).
//   Optional feature macro: CHUNK_COUNT_EN.
module signed_balance_drain #(
  parameter int ACC_W     = 8,
  parameter int DRAIN_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  signed_balance_drain_if.slave bus,
  output logic [ACC_W-1:0]     balance,
  output logic                 is_negative,
  output logic                 sat_flag,
  output logic                 settle_done
`ifdef CHUNK_COUNT_EN
  ,
  output logic [7:0]           chunk_count
`endif
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] BAL_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] BAL_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] CH_MAX  = ACC_W'(DRAIN_MAX);
  localparam logic signed [ACC_W-1:0] CH_MIN  = ACC_W'(-DRAIN_MAX);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] bal_q, bal_d;
  logic                    sat_q, sat_d;

  logic signed [ACC_W:0]   acc_sum;
  logic                    acc_clamp;
  logic signed [ACC_W-1:0] acc_sat;
  logic signed [ACC_W-1:0] chunk;
  logic signed [ACC_W-1:0] drain_rem;

  // Accumulation one bit wider than the balance; overflow shows up as the two
  // top bits disagreeing, and the top bit tells which rail to clamp to.
  always_comb begin
    acc_sum   = {bal_q[ACC_W-1], bal_q} + {{(ACC_W-4){bus.in_delta[4]}}, bus.in_delta};
    acc_clamp = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
    if (acc_clamp) begin
      acc_sat = acc_sum[ACC_W] ? BAL_MIN : BAL_MAX;
    end else begin
      acc_sat = acc_sum[ACC_W-1:0];
    end
  end

  // Chunk is the balance bounded to +/-DRAIN_MAX; it has the balance's sign and
  // no larger magnitude, so the remainder always moves toward zero.
  always_comb begin
    if (bal_q > CH_MAX) begin
      chunk = CH_MAX;
    end else if (bal_q < CH_MIN) begin
      chunk = CH_MIN;
    end else begin
      chunk = bal_q;
    end
    drain_rem = bal_q - chunk;
  end

  always_comb begin
    state_d = state_q;
    bal_d   = bal_q;
    sat_d   = sat_q;
    case (state_q)
      ACCUM: begin
        if (bus.in_valid) begin
          bal_d = acc_sat;
          sat_d = sat_q | acc_clamp;
        end
        // A delta accepted alongside settle_req is part of this settlement.
        if (bus.settle_req) begin
          state_d = (bal_d != '0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          bal_d = drain_rem;
          if (drain_rem == '0) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    if (clear) begin
      state_d = ACCUM;
      bal_d   = '0;
      sat_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      bal_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bal_q   <= bal_d;
      sat_q   <= sat_d;
    end
  end

  // Handshake outputs are decoded from state so they reset asynchronously.
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_value = (state_q == DRAIN) ? chunk[4:0] : '0;
  assign settle_done   = (state_q == DONE);
  assign balance       = bal_q;
  assign is_negative   = bal_q[ACC_W-1];
  assign sat_flag      = sat_q;

`ifdef CHUNK_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Cleared only when a settlement starts (leaving ACCUM), so the final count
  // survives the DRAIN->DONE step and holds until the next settle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ACCUM && state_d != ACCUM) begin
      cnt_d = '0;
    end else if (state_q == DRAIN && bus.out_ready && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (clear) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign chunk_count = cnt_q;
`endif

endmodule

// File: tb/tb_signed_balance_drain.sv
module tb_signed_balance_drain;
  localparam int ACC_W     = 8;
  localparam int DRAIN_MAX = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic [ACC_W-1:0] balance;
  logic             is_negative;
  logic             sat_flag;
  logic             settle_done;
`ifdef CHUNK_COUNT_EN
  logic [7:0]       chunk_count;
`endif

  signed_balance_drain_if bus ();

  signed_balance_drain #(
    .ACC_W     (ACC_W),
    .DRAIN_MAX (DRAIN_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .bus         (bus),
    .balance     (balance),
    .is_negative (is_negative),
    .sat_flag    (sat_flag),
    .settle_done (settle_done)
`ifdef CHUNK_COUNT_EN
    ,
    .chunk_count (chunk_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              clr;
    logic              iv;
    logic signed [4:0] d;
    logic              st;
    logic              ordy;
    int                bal;
    logic              irdy;
    logic              ov;
    logic signed [4:0] oval;
    logic              sat;
    logic              done;
  } vec_t;

  vec_t vecs[$];
  int   n_applied = 0;
  int   n_fail    = 0;

  task automatic add(input logic clr, input logic iv, input int d, input logic st,
                     input logic ordy, input int bal, input logic irdy, input logic ov,
                     input int oval, input logic sat, input logic done);
    vec_t v;
    v.clr  = clr;
    v.iv   = iv;
    v.d    = 5'(d);
    v.st   = st;
    v.ordy = ordy;
    v.bal  = bal;
    v.irdy = irdy;
    v.ov   = ov;
    v.oval = 5'(oval);
    v.sat  = sat;
    v.done = done;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic clr, input logic iv, input logic [4:0] d,
                       input logic st, input logic ordy);
    clear          = clr;
    bus.in_valid   = iv;
    bus.in_delta   = d;
    bus.settle_req = st;
    bus.out_ready  = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int ebal, input logic eirdy, input logic eov,
                     input logic [4:0] eoval, input logic esat, input logic edone);
    logic eneg;
    eneg = (ebal < 0);
    n_applied++;
    if (int'($signed(balance)) != ebal || is_negative !== eneg || bus.in_ready !== eirdy ||
        bus.out_valid !== eov || bus.out_value !== eoval || sat_flag !== esat ||
        settle_done !== edone) begin
      n_fail++;
      $display("FAIL %s: got bal=%0d neg=%b irdy=%b ov=%b oval=%b sat=%b done=%b; want bal=%0d neg=%b irdy=%b ov=%b oval=%b sat=%b done=%b",
               nm, $signed(balance), is_negative, bus.in_ready, bus.out_valid, bus.out_value,
               sat_flag, settle_done, ebal, eneg, eirdy, eov, eoval, esat, edone);
    end
  endtask

  initial begin
    // Accumulate
    add(0,1,5,0,0,   5,1,0,0,0,0);
    add(0,1,7,0,0,  12,1,0,0,0,0);
    add(0,1,-3,0,0,  9,1,0,0,0,0);
    add(1,0,0,0,0,   0,1,0,0,0,0);
    // Positive saturation
    for (int k = 1; k <= 9; k++) add(0,1,15,0,0, (k < 9) ? 15*k : 127, 1,0,0, (k == 9), 0);
    add(0,1,-16,0,0, 111,1,0,0,1,0);
    add(1,0,0,0,0,     0,1,0,0,0,0);
    // Positive drain, out_ready high
    add(0,1,15,0,0, 15,1,0,0,0,0);
    add(0,1,15,0,0, 30,1,0,0,0,0);
    add(0,1,7,0,0,  37,1,0,0,0,0);
    add(0,0,0,1,1,  37,0,1,15,0,0);
    add(0,0,0,0,1,  22,0,1,15,0,0);
    add(0,0,0,0,1,   7,0,1,7,0,0);
    add(0,0,0,0,1,   0,0,0,0,0,1);
    add(0,0,0,0,0,   0,1,0,0,0,0);
    // Negative drain with backpressure; deltas and settle_req ignored in DRAIN
    add(0,1,-16,0,0, -16,1,0,0,0,0);
    add(0,1,-4,0,0,  -20,1,0,0,0,0);
    add(0,0,0,1,0,   -20,0,1,-15,0,0);
    for (int k = 0; k < 3; k++) add(0,1,5,1,0, -20,0,1,-15,0,0);
    add(0,0,0,0,1,    -5,0,1,-5,0,0);
    add(0,0,0,0,1,     0,0,0,0,0,1);
    add(0,0,0,0,0,     0,1,0,0,0,0);
    // Abort with clear on the second chunk
    add(0,1,15,0,0, 15,1,0,0,0,0);
    add(0,1,15,0,0, 30,1,0,0,0,0);
    add(0,1,7,0,0,  37,1,0,0,0,0);
    add(0,0,0,1,1,  37,0,1,15,0,0);
    add(0,0,0,0,1,  22,0,1,15,0,0);
    add(1,0,0,0,1,   0,1,0,0,0,0);
    add(0,0,0,0,0,   0,1,0,0,0,0);
    // Settle on zero balance
    add(0,0,0,1,0,   0,0,0,0,0,1);
    add(0,0,0,0,0,   0,1,0,0,0,0);
    // Delta cancelling the balance in the settle cycle
    add(0,1,3,0,0,   3,1,0,0,0,0);
    add(0,1,-3,1,0,  0,0,0,0,0,1);
    add(0,0,0,0,0,   0,1,0,0,0,0);
    // Negative rail: -128 reached exactly, then clamp; long drain keeps sat_flag
    for (int k = 1; k <= 9; k++) add(0,1,-16,0,0, (k < 9) ? -16*k : -128, 1,0,0, (k == 9), 0);
    add(0,0,0,1,1, -128,0,1,-15,1,0);
    for (int k = 1; k <= 8; k++) add(0,0,0,0,1, -128+15*k, 0,1, (-128+15*k < -15) ? -15 : -128+15*k, 1,0);
    add(0,0,0,0,1,   0,0,0,0,1,1);
    add(0,0,0,0,0,   0,1,0,0,1,0);
    add(1,0,0,0,0,   0,1,0,0,0,0);

    rst            = 1'b1;
    clear          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_delta   = '0;
    bus.settle_req = 1'b0;
    bus.out_ready  = 1'b0;
    #12;
    chk("reset", 0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].iv, vecs[i].d, vecs[i].st, vecs[i].ordy);
      chk($sformatf("vec%0d", i), vecs[i].bal, vecs[i].irdy, vecs[i].ov, vecs[i].oval,
          vecs[i].sat, vecs[i].done);
    end

    // Drain of 37 with chunk counting, then asynchronous reset mid-drain
    drive(0, 1, 5'd15, 0, 0);
    drive(0, 1, 5'd15, 0, 0);
    drive(0, 1, 5'd7,  1, 0);
    chk("settle_w_delta", 37, 1'b0, 1'b1, 5'd15, 1'b0, 1'b0);
    drive(0, 0, 5'd0, 0, 1);
    drive(0, 0, 5'd0, 0, 1);
    drive(0, 0, 5'd0, 0, 1);
    chk("cnt_done", 0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
`ifdef CHUNK_COUNT_EN
    n_applied++;
    if (chunk_count !== 8'd3) begin
      n_fail++;
      $display("FAIL chunk_count_done: got %0d want 3", chunk_count);
    end
`endif
    drive(0, 0, 5'd0, 0, 0);
`ifdef CHUNK_COUNT_EN
    n_applied++;
    if (chunk_count !== 8'd3) begin
      n_fail++;
      $display("FAIL chunk_count_hold: got %0d want 3", chunk_count);
    end
`endif
    drive(0, 1, 5'd15, 0, 0);
    drive(0, 1, 5'd15, 1, 0);
    chk("pre_abort", 30, 1'b0, 1'b1, 5'd15, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive(0, 0, 5'd0, 0, 0);
    chk("post_rst", 0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end
endmodule
